// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared datapath definitions: word width, default transfer-counter width
//   and the destination select encoding used by the 1-to-2 demultiplexer.
//   No ports.
package cpu_pkg;

  localparam int DWIDTH = 32;
  localparam int CWIDTH = 8;

  // Destination select: 0 routes to output A, 1 routes to output B.
  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } dest_e;

endpackage

// File: rtl/demux1to2_buf_if.sv
// demux1to2_buf_if
//   Bundles the single input stream and the two output streams of the
//   1-to-2 demultiplexer, together with the per-output delivery counters.
//   Parameters: DWIDTH (word width), CWIDTH (delivery counter width).
//   Modports:
//     master - producer/consumer side: drives in_data, sel, in_valid,
//              a_ready, b_ready; observes everything else.
//     slave  - demultiplexer side: the mirror image of master.
interface demux1to2_buf_if
  import cpu_pkg::*;
#(
  parameter int DWIDTH = cpu_pkg::DWIDTH,
  parameter int CWIDTH = cpu_pkg::CWIDTH
);

  logic [DWIDTH-1:0] in_data;
  dest_e             sel;
  logic              in_valid;
  logic              in_ready;

  logic [DWIDTH-1:0] a_data;
  logic              a_valid;
  logic              a_ready;

  logic [DWIDTH-1:0] b_data;
  logic              b_valid;
  logic              b_ready;

  logic [CWIDTH-1:0] a_count;
  logic [CWIDTH-1:0] b_count;

  modport master (
    output in_data, sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

  modport slave (
    input  in_data, sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

endinterface

// File: rtl/demux_out_buf.sv
// demux_out_buf
//   Two-entry FIFO for one output of the demultiplexer, plus a delivery
//   counter that increments on every valid && ready handshake.
//   Ports:
//     clk, rst_n  clock; synchronous active-low reset
//     push        write push_data to the tail (ignored while full)
//     push_data   word to write
//     ready       consumer takes the head word when valid
//     full        buffer holds two words
//     valid       buffer holds at least one word
//     data        head word (holds its last value while empty)
//     count       number of delivered words, wrapping
module demux_out_buf #(
  parameter int DWIDTH = cpu_pkg::DWIDTH,
  parameter int CWIDTH = cpu_pkg::CWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              ready,
  output logic              full,
  output logic              valid,
  output logic [DWIDTH-1:0] data,
  output logic [CWIDTH-1:0] count
);

  // Entry 0 is always the head; entry 1 is the second word when present.
  logic [DWIDTH-1:0] mem_reg  [2];
  logic [DWIDTH-1:0] mem_next [2];
  logic [1:0]        fill_reg, fill_next;
  logic [CWIDTH-1:0] count_reg, count_next;
  logic              pop;
  logic              push_ok;

  assign full    = (fill_reg == 2'd2);
  assign valid   = (fill_reg != 2'd0);
  assign data    = mem_reg[0];
  assign count   = count_reg;
  assign pop     = valid && ready;
  // No pass-through when full: a pop in the same cycle does not free a slot.
  assign push_ok = push && !full;

  always_comb begin
    mem_next   = mem_reg;
    fill_next  = fill_reg;
    count_next = count_reg;

    if (pop) begin
      // Only shift when a second word exists, so an emptied buffer keeps
      // showing the word it last delivered.
      if (fill_reg == 2'd2) begin
        mem_next[0] = mem_reg[1];
      end
      count_next = count_reg + CWIDTH'(1);
    end

    if (push_ok) begin
      // The new word lands in slot 0 if the buffer is empty, or if the only
      // resident word leaves this same cycle; otherwise it queues in slot 1.
      if ((fill_reg == 2'd0) || pop) begin
        mem_next[0] = push_data;
      end else begin
        mem_next[1] = push_data;
      end
    end

    fill_next = fill_reg + 2'(push_ok) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_reg   <= '{default: '0};
      fill_reg  <= 2'd0;
      count_reg <= '0;
    end else begin
      mem_reg   <= mem_next;
      fill_reg  <= fill_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/demux1to2_buf.sv
// demux1to2_buf
//   Registered 1-to-2 demultiplexer: steers each accepted input word to
//   buffer A (sel = DEST_A) or buffer B (sel = DEST_B). Each output has its
//   own two-entry buffer, so a stalled consumer never blocks the other one.
//   Ports:
//     clk, rst_n  clock; synchronous active-low reset
//     bus         demux1to2_buf_if.slave carrying the input stream, both
//                 output streams and the two delivery counters
module demux1to2_buf
  import cpu_pkg::*;
#(
  parameter int DWIDTH = cpu_pkg::DWIDTH,
  parameter int CWIDTH = cpu_pkg::CWIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  demux1to2_buf_if.slave  bus
);

  // Index 0 is output A, index 1 is output B.
  logic [1:0]        push;
  logic [1:0]        ready;
  logic [1:0]        full;
  logic [1:0]        valid;
  logic [DWIDTH-1:0] data  [2];
  logic [CWIDTH-1:0] count [2];

  assign push[0] = bus.in_valid && bus.in_ready && (bus.sel == DEST_A);
  assign push[1] = bus.in_valid && bus.in_ready && (bus.sel == DEST_B);
  assign ready   = {bus.b_ready, bus.a_ready};

  // Readiness follows only the selected buffer and never in_valid; it is
  // held low while reset is asserted.
  assign bus.in_ready = rst_n && !((bus.sel == DEST_B) ? full[1] : full[0]);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      demux_out_buf #(
        .DWIDTH (DWIDTH),
        .CWIDTH (CWIDTH)
      ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push[gi]),
        .push_data (bus.in_data),
        .ready     (ready[gi]),
        .full      (full[gi]),
        .valid     (valid[gi]),
        .data      (data[gi]),
        .count     (count[gi])
      );
    end
  endgenerate

  assign bus.a_data  = data[0];
  assign bus.a_valid = valid[0];
  assign bus.a_count = count[0];
  assign bus.b_data  = data[1];
  assign bus.b_valid = valid[1];
  assign bus.b_count = count[1];

endmodule

// File: tb/tb_demux1to2_buf.sv
// tb_demux1to2_buf
//   Self-checking bench for demux1to2_buf. A queue-based reference model
//   (one queue per destination plus delivery counters) is advanced at every
//   rising edge from the inputs the DUT sees; scenario tasks compare the DUT
//   against that model and against constants from the directed scenarios.
module tb_demux1to2_buf;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux1to2_buf_if bus ();

  demux1to2_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [7:0]  ca = 8'd0;
  logic [7:0]  cb = 8'd0;
  bit          last_acc = 1'b0;

  // Advance one clock; update the model from the inputs present at the edge.
  task automatic tick();
    bit          acc, pa, pb;
    logic [31:0] d;
    dest_e       s;
    @(posedge clk);
    d = bus.in_data;
    s = bus.sel;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      ca = 8'd0;
      cb = 8'd0;
      last_acc = 1'b0;
    end else begin
      acc = bus.in_valid && ((s == DEST_A) ? (qa.size() < 2) : (qb.size() < 2));
      pa  = bus.a_ready && (qa.size() > 0);
      pb  = bus.b_ready && (qb.size() > 0);
      if (pa) begin void'(qa.pop_front()); ca = ca + 8'd1; end
      if (pb) begin void'(qb.pop_front()); cb = cb + 8'd1; end
      if (acc) begin
        if (s == DEST_A) qa.push_back(d);
        else             qb.push_back(d);
      end
      last_acc = acc;
    end
    #1;
  endtask

  task automatic drive(input bit v, input dest_e s, input logic [31:0] d);
    bus.in_valid = v;
    bus.sel      = s;
    bus.in_data  = d;
  endtask

  // Producer protocol monitor: a word offered but refused must be re-offered
  // unchanged at the next cycle.
  bit          pend = 1'b0;
  logic [31:0] pend_d;
  dest_e       pend_s;
  always @(negedge clk) begin
    if (pend && rst_n) begin
      checks++;
      if (!bus.in_valid || bus.in_data !== pend_d || bus.sel !== pend_s) begin
        errors++;
        $display("FAIL protocol_hold: got valid=%0b data=%h sel=%0d want valid=1 data=%h sel=%0d",
                 bus.in_valid, bus.in_data, bus.sel, pend_d, pend_s);
      end
    end
    pend   = rst_n && bus.in_valid && !bus.in_ready;
    pend_d = bus.in_data;
    pend_s = bus.sel;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    drive(1'b1, DEST_A, 32'hDEADBEEF);
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
    checks++;
    if ({bus.a_valid, bus.b_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", {bus.a_valid, bus.b_valid}); end
    checks++;
    if ({bus.a_count, bus.b_count} !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", {bus.a_count, bus.b_count}); end
    checks++;
    if ({bus.a_data, bus.b_data} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.a_data, bus.b_data}); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", bus.in_ready); end
    drive(1'b0, DEST_A, 32'h0);
    tick();
  endtask

  task automatic test_basic_steer();
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    drive(1'b1, DEST_A, 32'h01234567);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL steer_ready: got %0b want 1", bus.in_ready); end
    tick();
    drive(1'b1, DEST_B, 32'hFEDCBA98);
    #1;
    checks++;
    if ({bus.a_valid, bus.a_data} !== {1'b1, 32'h01234567}) begin
      errors++; $display("FAIL steer_a: got valid=%0b data=%h want valid=1 data=01234567", bus.a_valid, bus.a_data);
    end
    tick();
    drive(1'b0, DEST_A, 32'h0);
    #1;
    checks++;
    if ({bus.b_valid, bus.b_data} !== {1'b1, 32'hFEDCBA98}) begin
      errors++; $display("FAIL steer_b: got valid=%0b data=%h want valid=1 data=fedcba98", bus.b_valid, bus.b_data);
    end
    checks++;
    if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL steer_a_drained: got %0b want 0", bus.a_valid); end
    tick();
    checks++;
    if ({bus.a_count, bus.b_count} !== {8'd1, 8'd1}) begin
      errors++; $display("FAIL steer_counts: got a=%0d b=%0d want a=1 b=1", bus.a_count, bus.b_count);
    end
  endtask

  task automatic test_backpressure();
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b1;
    drive(1'b1, DEST_A, 32'hFFFFFFFF);
    tick();
    drive(1'b1, DEST_A, 32'hEEEEEEEE);
    tick();
    drive(1'b1, DEST_A, 32'h12345678);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_a_full_ready: got %0b want 0", bus.in_ready); end
    drive(1'b1, DEST_B, 32'h11111111);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_b_ready: got %0b want 1", bus.in_ready); end
    tick();
    drive(1'b0, DEST_A, 32'h0);
    #1;
    checks++;
    if ({bus.b_valid, bus.b_data} !== {1'b1, 32'h11111111}) begin
      errors++; $display("FAIL bp_b_word: got valid=%0b data=%h want valid=1 data=11111111", bus.b_valid, bus.b_data);
    end
    bus.a_ready = 1'b1;
    #1;
    checks++;
    if ({bus.a_valid, bus.a_data} !== {1'b1, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL bp_a_first: got valid=%0b data=%h want valid=1 data=ffffffff", bus.a_valid, bus.a_data);
    end
    tick();
    checks++;
    if ({bus.a_valid, bus.a_data} !== {1'b1, 32'hEEEEEEEE}) begin
      errors++; $display("FAIL bp_a_second: got valid=%0b data=%h want valid=1 data=eeeeeeee", bus.a_valid, bus.a_data);
    end
    tick();
    checks++;
    if ({bus.a_valid, bus.a_count} !== {1'b0, 8'd3}) begin
      errors++; $display("FAIL bp_a_done: got valid=%0b count=%0d want valid=0 count=3", bus.a_valid, bus.a_count);
    end
    checks++;
    if (bus.b_count !== cb) begin errors++; $display("FAIL bp_b_count: got %0d want %0d", bus.b_count, cb); end
  endtask

  task automatic test_full_pop();
    logic [31:0] r1, r2, r3;
    logic [7:0]  c0;
    r1 = $urandom; r2 = $urandom; r3 = $urandom;
    bus.a_ready = 1'b0;
    drive(1'b1, DEST_A, r1);
    tick();
    drive(1'b1, DEST_A, r2);
    tick();
    c0 = bus.a_count;
    bus.a_ready = 1'b1;
    drive(1'b1, DEST_A, r3);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_refused: got %0b want 0", bus.in_ready); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready_after: got %0b want 1", bus.in_ready); end
    checks++;
    if ({bus.a_valid, bus.a_data, bus.a_count} !== {1'b1, r2, c0 + 8'd1}) begin
      errors++; $display("FAIL full_pop_one_pop: got valid=%0b data=%h count=%0d want valid=1 data=%h count=%0d",
                         bus.a_valid, bus.a_data, bus.a_count, r2, c0 + 8'd1);
    end
    tick();
    drive(1'b0, DEST_A, 32'h0);
    bus.a_ready = 1'b0;
    #1;
    checks++;
    if ({bus.a_valid, bus.a_data} !== {1'b1, r3}) begin
      errors++; $display("FAIL full_pop_accepted: got valid=%0b data=%h want valid=1 data=%h", bus.a_valid, bus.a_data, r3);
    end
    bus.a_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0;
    checks++;
    if ({bus.a_valid, bus.a_count} !== {1'b0, c0 + 8'd3}) begin
      errors++; $display("FAIL full_pop_drain: got valid=%0b count=%0d want valid=0 count=%0d", bus.a_valid, bus.a_count, c0 + 8'd3);
    end
  endtask

  task automatic test_count1();
    bus.a_ready = 1'b0;
    drive(1'b1, DEST_A, 32'h0000000A);
    tick();
    drive(1'b0, DEST_A, 32'h0);
    #1;
    checks++;
    if ({bus.a_valid, bus.a_data} !== {1'b1, 32'h0000000A}) begin
      errors++; $display("FAIL count1_first: got valid=%0b data=%h want valid=1 data=0000000a", bus.a_valid, bus.a_data);
    end
    bus.a_ready = 1'b1;
    drive(1'b1, DEST_A, 32'h0000000B);
    tick();
    drive(1'b0, DEST_A, 32'h0);
    bus.a_ready = 1'b0;
    #1;
    checks++;
    if ({bus.a_valid, bus.a_data} !== {1'b1, 32'h0000000B}) begin
      errors++; $display("FAIL count1_swap: got valid=%0b data=%h want valid=1 data=0000000b", bus.a_valid, bus.a_data);
    end
    checks++;
    if (bus.a_count !== ca) begin errors++; $display("FAIL count1_count: got %0d want %0d", bus.a_count, ca); end
    bus.a_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0;
  endtask

  task automatic test_random(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      if (!bus.in_valid || last_acc) begin
        if ($urandom_range(0, 3) != 0) drive(1'b1, dest_e'($urandom_range(0, 1)), $urandom);
        else                           drive(1'b0, DEST_A, 32'h0);
      end
      bus.a_ready = 1'($urandom_range(0, 1));
      bus.b_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus.in_ready !== ((bus.sel == DEST_A) ? (qa.size() < 2) : (qb.size() < 2))) begin
        errors++; $display("FAIL rand_in_ready: cycle %0d got %0b sel=%0d qa=%0d qb=%0d", i, bus.in_ready, bus.sel, qa.size(), qb.size());
      end
      checks++;
      if (bus.a_valid !== (qa.size() != 0) || (qa.size() != 0 && bus.a_data !== qa[0]) || bus.a_count !== ca) begin
        errors++; $display("FAIL rand_a: cycle %0d got valid=%0b data=%h count=%0d want valid=%0b data=%h count=%0d",
                           i, bus.a_valid, bus.a_data, bus.a_count, qa.size() != 0, (qa.size() != 0) ? qa[0] : 32'h0, ca);
      end
      checks++;
      if (bus.b_valid !== (qb.size() != 0) || (qb.size() != 0 && bus.b_data !== qb[0]) || bus.b_count !== cb) begin
        errors++; $display("FAIL rand_b: cycle %0d got valid=%0b data=%h count=%0d want valid=%0b data=%h count=%0d",
                           i, bus.b_valid, bus.b_data, bus.b_count, qb.size() != 0, (qb.size() != 0) ? qb[0] : 32'h0, cb);
      end
      tick();
    end
    // Let any still-pending word be accepted before dropping in_valid.
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    k = 0;
    while (bus.in_valid && !last_acc && k < 10) begin
      tick();
      k++;
    end
    checks++;
    if (bus.in_valid && !last_acc) begin errors++; $display("FAIL rand_drain_timeout: word still pending after %0d cycles", k); end
    drive(1'b0, DEST_A, 32'h0);
    tick();
    tick();
    checks++;
    if ({bus.a_valid, bus.b_valid, bus.a_count, bus.b_count} !== {2'b00, ca, cb}) begin
      errors++; $display("FAIL rand_final: got valid=%b a=%0d b=%0d want valid=00 a=%0d b=%0d",
                         {bus.a_valid, bus.b_valid}, bus.a_count, bus.b_count, ca, cb);
    end
  endtask

  task automatic test_wrap();
    int stalls;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, DEST_B, i);
      #1;
      if (bus.in_ready !== 1'b1) stalls++;
      tick();
    end
    drive(1'b0, DEST_A, 32'h0);
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL wrap_throughput: got %0d stalled cycles want 0", stalls); end
    checks++;
    if ({bus.b_valid, bus.b_data, bus.b_count} !== {1'b1, 32'd255, 8'd255}) begin
      errors++; $display("FAIL wrap_255: got valid=%0b data=%h count=%0d want valid=1 data=000000ff count=255",
                         bus.b_valid, bus.b_data, bus.b_count);
    end
    tick();
    checks++;
    if ({bus.b_valid, bus.b_count} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL wrap_zero: got valid=%0b count=%0d want valid=0 count=0", bus.b_valid, bus.b_count);
    end
  endtask

  task automatic test_mid_reset();
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    drive(1'b1, DEST_A, $urandom); tick();
    drive(1'b1, DEST_A, $urandom); tick();
    drive(1'b1, DEST_B, $urandom); tick();
    drive(1'b1, DEST_B, $urandom); tick();
    drive(1'b0, DEST_A, 32'h0);
    bus.a_ready = 1'b1;
    tick();
    bus.b_ready = 1'b1;
    checks++;
    if ({bus.a_valid, bus.b_valid, bus.a_count} !== {2'b11, 8'd1}) begin
      errors++; $display("FAIL midrst_pre: got valid=%b a_count=%0d want valid=11 a_count=1", {bus.a_valid, bus.b_valid}, bus.a_count);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.a_valid, bus.b_valid, bus.a_count, bus.b_count} !== {2'b00, 16'h0}) begin
      errors++; $display("FAIL midrst_cleared: got valid=%b a=%0d b=%0d want valid=00 a=0 b=0",
                         {bus.a_valid, bus.b_valid}, bus.a_count, bus.b_count);
    end
    checks++;
    if ({bus.a_data, bus.b_data, bus.in_ready} !== 65'h0) begin
      errors++; $display("FAIL midrst_data: got a=%h b=%h in_ready=%0b want 0 0 0", bus.a_data, bus.b_data, bus.in_ready);
    end
    rst_n = 1'b1;
    drive(1'b1, DEST_A, 32'hC0FFEE00);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", bus.in_ready); end
    tick();
    drive(1'b0, DEST_A, 32'h0);
    #1;
    checks++;
    if ({bus.a_valid, bus.a_data} !== {1'b1, 32'hC0FFEE00}) begin
      errors++; $display("FAIL midrst_first: got valid=%0b data=%h want valid=1 data=c0ffee00", bus.a_valid, bus.a_data);
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.sel      = DEST_A;
    bus.in_data  = 32'h0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    test_reset();
    test_basic_steer();
    test_backpressure();
    test_full_pop();
    test_count1();
    test_random(400);
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to2_buf.md
# demux1to2_buf

Registered 1-to-2 demultiplexer for the 32-bit datapath: the inverse of the 2:1 mux. It steers one valid/ready input stream to one of two output streams, A or B, chosen per word by `sel`. Each output has a 2-entry buffer, so a stalled destination never blocks words bound for the other. It sits between a single result producer and two consumers, e.g. a writeback split between the register file and a store path.

## Interface
- `DWIDTH`, 32, data width of every word.
- `CWIDTH`, 8, width of each per-output transfer counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  DWIDTH  input word.
- `sel`  in  1  destination select: 0 routes to A, 1 routes to B; sampled with `in_data`.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept the word on the selected destination this cycle.
- `a_data`  out  DWIDTH  head word of buffer A.
- `a_valid`  out  1  buffer A non-empty.
- `a_ready`  in  1  consumer A takes the head word.
- `b_data`  out  DWIDTH  head word of buffer B.
- `b_valid`  out  1  buffer B non-empty.
- `b_ready`  in  1  consumer B takes the head word.
- `a_count`  out  CWIDTH  number of words delivered on A (`a_valid && a_ready`), modulo 2^CWIDTH.
- `b_count`  out  CWIDTH  number of words delivered on B, same rule.

## Operation
- Push: when `in_valid && in_ready` at a rising edge, `in_data` is written to the tail of buffer A if `sel` = 0, otherwise to buffer B. The other buffer is untouched.
- `in_ready` is `!full` of the buffer selected by the current `sel`. It is combinational from `sel` and the buffer state, and never depends on `in_valid`.
- Pop: when `x_valid && x_ready` at a rising edge, the head entry of buffer x is removed and `x_count` increments.
- Each buffer holds a count in the range 0..2. The head is always driven on `x_data`. `x_valid` = (count != 0).
- Order: words within one destination leave in arrival order. There is no ordering constraint between A and B.
- Simultaneous push and pop on the same buffer with count 1: the count stays 1, the old head leaves, and the new word becomes the head next cycle.
- Simultaneous push and pop with count 0 is impossible: a pop requires valid. A push to an empty buffer is visible the next cycle. There is no combinational bypass.
- Full (count 2): `in_ready` = 0 for that destination, even if `x_ready` = 1 in the same cycle. There is no pass-through when full.
- Empty: `x_data` holds its last value, and the consumer must ignore it.
- Counters wrap from 2^CWIDTH−1 to 0 without saturation or flag.
- Protocol rules for the producer: once `in_valid` is raised it stays high, and `in_data`/`sel` stay stable, until accepted. The block does not check this; the bench asserts it.

## Timing
- Latency: a word accepted at edge N is on `x_data` with `x_valid` = 1 after edge N, when that buffer was empty.
- Throughput: one word per cycle into each destination while its consumer keeps `x_ready` = 1.
- Reset (`rst_n` = 0 at an edge): both buffer counts go to 0, `a_valid`/`b_valid` = 0, `a_data`/`b_data` = 0, and both counters = 0.
- While `rst_n` = 0, `in_ready` is forced to 0.
- Reset mid-operation: all buffered words are discarded and no pop is counted at the reset edge. The first acceptance is possible at the first edge with `rst_n` = 1.

## Structure
- Shared package `cpu_pkg` holds:
  - `DWIDTH` = 32;
  - enum `dest_e` {DEST_A = 1'b0, DEST_B = 1'b1}, used for `sel`.
- Sub-module `demux_out_buf`: a 2-entry FIFO with push/pop, full/empty, head data, and a delivery counter. It is instantiated twice.
- The top level holds only the select decode and the `in_ready` mux.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 → `in_ready` = 0, `a_valid` = `b_valid` = 0, `a_count` = `b_count` = 0. Release reset → `in_ready` = 1.
- Basic steer: with both readies = 1, push 32'h01234567 with `sel` = 0, then 32'hFEDCBA98 with `sel` = 1.
  - A shows 01234567 one cycle after acceptance.
  - B shows FEDCBA98 one cycle after its acceptance.
  - End state: `a_count` = 1, `b_count` = 1.
- Backpressure isolation: `a_ready` = 0, push FFFFFFFF and EEEEEEEE to A.
  - A third push to A sees `in_ready` = 0.
  - With `sel` = 1 the same cycle, `in_ready` = 1 and 32'h11111111 reaches B.
  - Raising `a_ready` → A delivers FFFFFFFF then EEEEEEEE in order.
- Full plus pop: with A full, `a_ready` = 1 and a push to A in the same cycle → push refused, one pop. Next cycle `in_ready` = 1 and the push is accepted.
- Count-1 simultaneous push/pop: with A holding 0xA, push 0xB while popping → `a_valid` stays 1 and `a_data` = 0xB next cycle.
- Wrap and mid-reset:
  - 256 deliveries on B → `b_count` returns to 0.
  - Assert reset with both buffers holding words → both empty next cycle and counters = 0.
